// File: rtl/multiplier_arbiter.sv
// ---------------------------------------------------------------------------
// multiplier_arbiter
//
// Two requesters share one sequential shift-add multiplier. A three-state
// FSM (IDLE -> COMPUTE -> DONE) serves one request at a time. When both
// requesters ask in the same IDLE cycle, the one not served last wins.
//
// Timing for one operation (W = p_data_width):
//   cycle 0      IDLE, o_w_gntX high (combinational); operands are captured
//                on the closing edge
//   cycles 1..W  COMPUTE, one multiplier bit per cycle
//   cycle W+1    DONE, o_w_doneX high and o_w_outX holds the new product
//   cycle W+2    IDLE again; the next grant can happen here
//
// Ports
//   i_w_clk              clock; all state changes on the rising edge
//   i_w_reset            asynchronous, active-low reset
//   i_w_req0/1           request from requester 0/1
//   i_w_a0/1, i_w_b0/1   unsigned W-bit operands for each requester
//   o_w_gnt0/1           grant, combinational, high only in IDLE
//   o_w_done0/1          one-cycle completion pulse, registered
//   o_w_out0/1           last 2W-bit product for each requester, registered
//   o_w_busy             high in every state except IDLE, registered
//   o_w_owner            index of the requester being served, registered
// ---------------------------------------------------------------------------
module multiplier_arbiter #(
    parameter int p_data_width = 7
) (
    input  logic                        i_w_clk,
    input  logic                        i_w_reset,
    input  logic                        i_w_req0,
    input  logic [p_data_width-1:0]     i_w_a0,
    input  logic [p_data_width-1:0]     i_w_b0,
    input  logic                        i_w_req1,
    input  logic [p_data_width-1:0]     i_w_a1,
    input  logic [p_data_width-1:0]     i_w_b1,
    output logic                        o_w_gnt0,
    output logic                        o_w_gnt1,
    output logic                        o_w_done0,
    output logic                        o_w_done1,
    output logic [2*p_data_width-1:0]   o_w_out0,
    output logic [2*p_data_width-1:0]   o_w_out1,
    output logic                        o_w_busy,
    output logic                        o_w_owner
);

    localparam int W         = p_data_width;
    localparam int c_cnt_w   = (W > 1) ? $clog2(W) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } t_state;

    t_state             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2*W-1:0]     r_a;        // multiplicand, shifted left each step
    logic [W-1:0]       r_b;        // multiplier, shifted right each step
    logic [2*W-1:0]     r_acc;      // running partial product
    logic               r_owner;
    logic               r_busy;
    logic               r_last;     // requester served most recently

    logic               w_idle;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_any_gnt;
    logic [W-1:0]       w_sel_a;
    logic [W-1:0]       w_sel_b;
    logic [2*W-1:0]     w_acc_next;
    logic               w_last_step;

    // -----------------------------------------------------------------------
    // Grant decode. Gated by reset so no grant appears while reset is held.
    // On a tie the requester other than r_last wins; r_last resets to 1 so
    // requester 0 wins the first tie.
    // -----------------------------------------------------------------------
    assign w_idle    = (r_state == S_IDLE) && i_w_reset;
    assign w_gnt0    = w_idle && i_w_req0 && (!i_w_req1 || r_last);
    assign w_gnt1    = w_idle && i_w_req1 && (!i_w_req0 || !r_last);
    assign w_any_gnt = w_gnt0 || w_gnt1;

    assign w_sel_a = w_gnt1 ? i_w_a1 : i_w_a0;
    assign w_sel_b = w_gnt1 ? i_w_b1 : i_w_b0;

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier bit is set. Zero operands still take all W steps.
    assign w_acc_next  = r_acc + (r_b[0] ? r_a : '0);
    assign w_last_step = (r_state == S_COMPUTE) && (r_cnt == '0);

    // -----------------------------------------------------------------------
    // Main FSM and datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_owner <= 1'b0;
            r_busy  <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_gnt) begin
                        r_owner <= w_gnt1;
                        r_a     <= {{W{1'b0}}, w_sel_a};
                        r_b     <= w_sel_b;
                        r_acc   <= '0;
                        r_cnt   <= c_cnt_init;
                        r_busy  <= 1'b1;
                        r_state <= S_COMPUTE;
                    end
                end

                S_COMPUTE: begin
                    r_acc <= w_acc_next;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end

                S_DONE: begin
                    // Pointer moves as DONE closes so the very next IDLE
                    // cycle already favours the other requester.
                    r_last  <= r_owner;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Per-requester result registers. The product and done pulse are loaded
    // on the edge that closes the final COMPUTE step, so both are visible
    // throughout the DONE cycle. Only the owner's registers change.
    // -----------------------------------------------------------------------
    logic [2*W-1:0] w_out  [2];
    logic           w_done [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic [2*W-1:0] r_out;
            logic           r_done;
            logic           w_finish;

            assign w_finish = w_last_step && (r_owner == 1'(gi));

            always_ff @(posedge i_w_clk or negedge i_w_reset) begin
                if (!i_w_reset) begin
                    r_out  <= '0;
                    r_done <= 1'b0;
                end else begin
                    r_done <= w_finish;
                    if (w_finish) begin
                        r_out <= w_acc_next;
                    end
                end
            end

            assign w_out[gi]  = r_out;
            assign w_done[gi] = r_done;
        end
    endgenerate

    assign o_w_gnt0  = w_gnt0;
    assign o_w_gnt1  = w_gnt1;
    assign o_w_done0 = w_done[0];
    assign o_w_done1 = w_done[1];
    assign o_w_out0  = w_out[0];
    assign o_w_out1  = w_out[1];
    assign o_w_busy  = r_busy;
    assign o_w_owner = r_owner;

endmodule
